// File: rtl/lc3b_mem_responder.sv
// Fixed-latency word memory behind the LC-3b mem_* port, with byte-lane
// writes, completed-transaction counters and a sticky read+write error flag.
module lc3b_mem_responder #(
    parameter int ADDR_BITS = 8,
    parameter int LATENCY   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  mem_byte_enable,
    input  logic [15:0] mem_address,
    input  logic [15:0] mem_wdata,
    output logic        mem_resp,
    output logic [15:0] mem_rdata,
    output logic [15:0] rd_count,
    output logic [15:0] wr_count,
    output logic        proto_err
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    state_e                 state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic                   rd_op_q, rd_op_d;
    logic [ADDR_BITS-1:0]   idx_q, idx_d;
    logic [1:0]             be_q, be_d;
    logic [15:0]            wdata_q, wdata_d;
    logic [15:0]            rdata_q, rdata_d;
    logic [15:0]            rd_cnt_q, rd_cnt_d;
    logic [15:0]            wr_cnt_q, wr_cnt_d;
    logic                   perr_q, perr_d;

    // Commit port: normally fed from the captured request, but with a
    // one-cycle latency the commit happens on the acceptance edge itself.
    logic                   commit;
    logic                   c_rd;
    logic [ADDR_BITS-1:0]   c_idx;
    logic [1:0]             c_be;
    logic [15:0]            c_wdata;

    logic [15:0] mem_q [2**ADDR_BITS];

    // Next-state, capture and commit decode
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rd_op_d  = rd_op_q;
        idx_d    = idx_q;
        be_d     = be_q;
        wdata_d  = wdata_q;
        perr_d   = perr_q;
        commit   = 1'b0;
        c_rd     = rd_op_q;
        c_idx    = idx_q;
        c_be     = be_q;
        c_wdata  = wdata_q;
        unique case (state_q)
            IDLE: begin
                if (mem_read | mem_write) begin
                    // Read wins when both are asserted; the error is latched.
                    rd_op_d = mem_read;
                    idx_d   = mem_address[ADDR_BITS:1];
                    be_d    = mem_byte_enable;
                    wdata_d = mem_wdata;
                    cnt_d   = CNT_LOAD;
                    if (mem_read && mem_write) perr_d = 1'b1;
                    if (LATENCY == 1) begin
                        state_d = RESP;
                        commit  = 1'b1;
                        c_rd    = mem_read;
                        c_idx   = mem_address[ADDR_BITS:1];
                        c_be    = mem_byte_enable;
                        c_wdata = mem_wdata;
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_d == 4'd0) begin
                    state_d = RESP;
                    commit  = 1'b1;
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Read data and counters update on the commit edge
    always_comb begin
        rdata_d  = rdata_q;
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        if (commit) begin
            if (c_rd) begin
                rdata_d  = mem_q[c_idx];
                rd_cnt_d = rd_cnt_q + 16'd1;
            end else begin
                wr_cnt_d = wr_cnt_q + 16'd1;
            end
        end
    end

    // Control and output registers; reset aborts any in-flight transaction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rd_op_q  <= 1'b0;
            idx_q    <= '0;
            be_q     <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
            perr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rd_op_q  <= rd_op_d;
            idx_q    <= idx_d;
            be_q     <= be_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
            perr_q   <= perr_d;
        end
    end

    // Storage array: not reset, byte-lane writes on the commit edge
    always_ff @(posedge clk) begin
        if (rst_n && commit && !c_rd) begin
            if (c_be[0]) mem_q[c_idx][7:0]  <= c_wdata[7:0];
            if (c_be[1]) mem_q[c_idx][15:8] <= c_wdata[15:8];
        end
    end

    assign mem_resp  = (state_q == RESP);
    assign mem_rdata = rdata_q;
    assign rd_count  = rd_cnt_q;
    assign wr_count  = wr_cnt_q;
    assign proto_err = perr_q;

endmodule

// File: tb/tb_lc3b_mem_responder.sv
// Bench for lc3b_mem_responder: transaction-level model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_lc3b_mem_responder;

    localparam int AB  = 8;
    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_read, mem_write;
    logic [1:0]  mem_byte_enable;
    logic [15:0] mem_address, mem_wdata;
    logic        mem_resp;
    logic [15:0] mem_rdata, rd_count, wr_count;
    logic        proto_err;

    lc3b_mem_responder #(.ADDR_BITS(AB), .LATENCY(LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_byte_enable(mem_byte_enable), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_resp(mem_resp), .mem_rdata(mem_rdata),
        .rd_count(rd_count), .wr_count(wr_count), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- transaction-level model ----------------
    logic [15:0] m_mem [2**AB];
    logic        m_pend;
    int          m_resp_cyc;
    logic        m_isrd;
    logic [AB-1:0] m_idx;
    logic [1:0]  m_be;
    logic [15:0] m_wd, m_rdata, m_rd, m_wr;
    logic        m_perr;

    always @(posedge clk) cyc <= cyc + 1;

    // The edge ending cycle `cyc`: a request is taken when nothing is
    // outstanding; its effects land one edge before its response cycle.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pend = 0; m_rdata = 0; m_rd = 0; m_wr = 0; m_perr = 0; m_resp_cyc = 0;
        end else begin
            if (m_pend && cyc == m_resp_cyc) m_pend = 0;
            else if (!m_pend && (mem_read || mem_write)) begin
                m_pend = 1;
                m_resp_cyc = cyc + LAT;
                m_isrd = mem_read;
                m_idx = mem_address[AB:1];
                m_be = mem_byte_enable;
                m_wd = mem_wdata;
                if (mem_read && mem_write) m_perr = 1;
            end
            if (m_pend && cyc == m_resp_cyc - 1) begin
                if (m_isrd) begin
                    m_rdata = m_mem[m_idx];
                    m_rd = m_rd + 1;
                end else begin
                    if (m_be[0]) m_mem[m_idx][7:0] = m_wd[7:0];
                    if (m_be[1]) m_mem[m_idx][15:8] = m_wd[15:8];
                    m_wr = m_wr + 1;
                end
            end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        #1;
        chk("resp", mem_resp, (m_pend && cyc == m_resp_cyc));
        chk("rdata", mem_rdata, m_rdata);
        chk("rd_count", rd_count, m_rd);
        chk("wr_count", wr_count, m_wr);
        chk("proto_err", proto_err, m_perr);
    end

    // ---------------- stimulus helpers ----------------
    task automatic preload(input int w, input logic [15:0] v);
        dut.mem_q[w] = v;
        m_mem[w] = v;
    endtask

    task automatic issue(input logic r, input logic w, input logic [1:0] b,
                         input logic [15:0] a, input logic [15:0] d);
        mem_read = r; mem_write = w; mem_byte_enable = b; mem_address = a; mem_wdata = d;
    endtask

    task automatic idle();
        mem_read = 0; mem_write = 0;
    endtask

    task automatic wait_resp(output int rc);
        rc = -1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (mem_resp) begin rc = cyc; break; end
        end
        if (rc < 0) chk("resp_timeout", 0, 1);
    endtask

    // Issue, wait for the response, release and let RESP pass
    task automatic txn(input logic r, input logic w, input logic [1:0] b,
                       input logic [15:0] a, input logic [15:0] d, output int lat);
        int k, rc;
        k = cyc;
        issue(r, w, b, a, d);
        wait_resp(rc);
        idle();
        lat = rc - k;
        @(negedge clk);
    endtask

    initial begin
        int lat, k, r1, r2, nresp;
        rst_n = 0;
        issue(1, 0, 2'b00, 16'h000A, 16'h0000);
        for (int i = 0; i < 2**AB; i++) preload(i, 16'h0000);
        preload(5, 16'hBEEF);
        preload(3, 16'h1234);
        preload(2, 16'h0F0F);

        // Reset held with a read pending: nothing responds
        nresp = 0;
        repeat (6) begin @(negedge clk); if (mem_resp) nresp++; end
        chk("rst_no_resp", nresp, 0);
        chk("rst_rdata", mem_rdata, 16'h0000);
        chk("rst_rd_count", rd_count, 0);
        chk("rst_proto_err", proto_err, 0);
        idle();
        rst_n = 1;
        @(negedge clk);

        // Read latency
        txn(1, 0, 2'b00, 16'h000A, 16'h0, lat);
        chk("rd_latency", lat, LAT);
        chk("rd_data", mem_rdata, 16'hBEEF);
        chk("rd_count1", rd_count, 1);

        // Byte-lane writes
        txn(0, 1, 2'b01, 16'h0007, 16'hABCD, lat);
        chk("wr_latency", lat, LAT);
        txn(1, 0, 2'b00, 16'h0006, 16'h0, lat);
        chk("lane_lo", mem_rdata, 16'h12CD);
        preload(3, 16'h1234);
        txn(0, 1, 2'b10, 16'h0007, 16'hABCD, lat);
        txn(1, 0, 2'b00, 16'h0006, 16'h0, lat);
        chk("lane_hi", mem_rdata, 16'hAB34);
        chk("wr_count2", wr_count, 2);

        // Aliasing: high address bits and bit 0 ignored
        txn(1, 0, 2'b00, 16'hFE0B, 16'h0, lat);
        chk("alias", mem_rdata, 16'hBEEF);

        // Back-to-back held read
        k = cyc;
        issue(1, 0, 2'b00, 16'h000A, 16'h0);
        wait_resp(r1);
        wait_resp(r2);
        idle();
        chk("b2b_first", r1 - k, LAT);
        chk("b2b_second", r2 - k, 2*LAT + 1);
        @(negedge clk);

        // Request dropped while busy still completes
        k = cyc;
        issue(1, 0, 2'b00, 16'h0006, 16'h0);
        @(negedge clk);
        idle();
        wait_resp(r1);
        chk("drop_latency", r1 - k, LAT);
        chk("drop_data", mem_rdata, 16'hAB34);
        @(negedge clk);

        // Read and write together: error flag, handled as a read
        txn(1, 1, 2'b11, 16'h0004, 16'hFFFF, lat);
        chk("perr_flag", proto_err, 1);
        chk("perr_data", mem_rdata, 16'h0F0F);
        chk("perr_word2", dut.mem_q[2], 16'h0F0F);
        chk("perr_rd_count", rd_count, 8);
        chk("perr_wr_count", wr_count, 2);

        // Reset in the middle of a write
        issue(0, 1, 2'b11, 16'h0002, 16'h5555);
        repeat (2) @(negedge clk);
        rst_n = 0;
        idle();
        @(negedge clk);
        rst_n = 1;
        nresp = 0;
        repeat (8) begin @(negedge clk); if (mem_resp) nresp++; end
        chk("abort_no_resp", nresp, 0);
        chk("abort_word1", dut.mem_q[1], 16'h0000);
        chk("abort_counts", {rd_count, wr_count}, 32'h0);
        chk("abort_perr", proto_err, 0);
        txn(1, 0, 2'b00, 16'h0002, 16'h0, lat);
        chk("post_rst_latency", lat, LAT);
        chk("post_rst_data", mem_rdata, 16'h0000);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
